// File: rtl/acc_out_port_if.sv
// Handshake/status bundle between the accumulator output port and its users.
// ACC_OUT_PARITY_EN adds the out_parity signal to the bundle.
interface acc_out_port_if #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              ovf_clr;
   logic              full;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
`ifdef ACC_OUT_PARITY_EN
   logic              out_parity;

   modport master (
      output wr_en, wr_data, ovf_clr, out_ready,
      input  full, count, overflow, out_valid, out_data, out_parity
   );
   modport slave (
      input  wr_en, wr_data, ovf_clr, out_ready,
      output full, count, overflow, out_valid, out_data, out_parity
   );
`else
   modport master (
      output wr_en, wr_data, ovf_clr, out_ready,
      input  full, count, overflow, out_valid, out_data
   );
   modport slave (
      input  wr_en, wr_data, ovf_clr, out_ready,
      output full, count, overflow, out_valid, out_data
   );
`endif
endinterface

// File: rtl/acc_out_port.sv
// Accumulator output port: queues stored bytes in a small FWFT FIFO, drops and flags on full.
// ACC_OUT_PARITY_EN stores even parity with each entry and presents it as out_parity.
module acc_out_port #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic           clk_i,
   input  logic           rst_ni,
   acc_out_port_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
`ifdef ACC_OUT_PARITY_EN
   localparam int ENT_W = DATA_W + 1;
`else
   localparam int ENT_W = DATA_W;
`endif

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             full, empty, pop, push, drop;
   logic [ENT_W-1:0] wr_entry;
   logic [ENT_W-1:0] head;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);

`ifdef ACC_OUT_PARITY_EN
   assign wr_entry = {^bus.wr_data, bus.wr_data};
`else
   assign wr_entry = bus.wr_data;
`endif

   always_comb begin
      pop      = ~empty & bus.out_ready;
      // A full FIFO still accepts a store when the head leaves in the same cycle.
      push     = bus.wr_en & (~full | pop);
      drop     = bus.wr_en & ~push;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      // Drop wins over a same-cycle clear so no lost byte goes unreported.
      if (drop)             ovf_d = 1'b1;
      else if (bus.ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage needs no reset: every read is qualified by count.
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= wr_entry;
   end

   assign head          = empty ? '0 : mem_q[rd_ptr_q];
   assign bus.full      = full;
   assign bus.count     = count_q;
   assign bus.overflow  = ovf_q;
   assign bus.out_valid = ~empty;
   assign bus.out_data  = head[DATA_W-1:0];
`ifdef ACC_OUT_PARITY_EN
   assign bus.out_parity = head[DATA_W];
`endif
endmodule
